// File: rtl/solver_seq_pkg.sv
// Shared definitions for the solver sequencer: state codes, bus widths and the
// work bundle handed to the block_solver core.
package solver_seq_pkg;

    localparam int MIDSTATE_W  = 256;
    localparam int LEFTOVERS_W = 96;
    localparam int TARGET_W    = 256;
    localparam int NONCE_W     = 32;
    localparam int FOUND_BIT   = 2;

    // Codes are also decoded by the register-file status view.
    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_LOAD      = 3'd1,
        SEQ_HOLD      = 3'd2,
        SEQ_RUN       = 3'd3,
        SEQ_FOUND     = 3'd4,
        SEQ_EXHAUSTED = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic [MIDSTATE_W-1:0]  midstate;
        logic [LEFTOVERS_W-1:0] leftovers;
        logic [TARGET_W-1:0]    target;
    } work_t;

    function automatic logic is_busy(input logic [2:0] st);
        return (st == SEQ_LOAD) || (st == SEQ_HOLD) || (st == SEQ_RUN);
    endfunction

endpackage

// File: rtl/solver_sequencer_work_latch.sv
// Load-enabled register holding the 608-bit work bundle for the running job.
module work_latch
    import solver_seq_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  work_t d,
    output work_t q
);

    // NOTE: this is a plain register bank, not a RAM, so clearing it in reset is
    // cheap and keeps the solver inputs at a known value out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/solver_sequencer.sv
// Sequences one mining job on the block_solver: snapshot work, hold the solver
// in reset for RST_CYCLES, run it, and latch the outcome for the register file.
module solver_sequencer
    import solver_seq_pkg::*;
#(
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] MAX_NONCE  = 32'hFFFF_FFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [MIDSTATE_W-1:0]  work_midstate,
    input  logic [LEFTOVERS_W-1:0] work_leftovers,
    input  logic [TARGET_W-1:0]    work_target,
    input  logic [2:0]             solver_state,
    input  logic [NONCE_W-1:0]     solver_nonce,
    output logic                   solver_rst_n,
    output logic [MIDSTATE_W-1:0]  solver_midstate,
    output logic [LEFTOVERS_W-1:0] solver_leftovers,
    output logic [TARGET_W-1:0]    solver_target,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             status,
    output logic [NONCE_W-1:0]     result_nonce
);

    localparam logic [2:0] ST_IDLE      = SEQ_IDLE;
    localparam logic [2:0] ST_LOAD      = SEQ_LOAD;
    localparam logic [2:0] ST_HOLD      = SEQ_HOLD;
    localparam logic [2:0] ST_RUN       = SEQ_RUN;
    localparam logic [2:0] ST_FOUND     = SEQ_FOUND;
    localparam logic [2:0] ST_EXHAUSTED = SEQ_EXHAUSTED;
    localparam logic [3:0] HOLD_LAST    = 4'(RST_CYCLES - 1);

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] hold_cnt;
    logic       found;
    work_t      work_in;
    work_t      work_q;

    // Only the found flag matters to sequencing; the low state bits are ignored.
    logic [1:0] unused_solver_state;
    assign unused_solver_state = solver_state[1:0];
    assign found = solver_state[FOUND_BIT];

    // NOTE: every path assigns next_state, starting from a default, so no latch
    // is inferred for it.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start) next_state = ST_LOAD;
                ST_LOAD:      next_state = start ? ST_LOAD : ST_HOLD;
                ST_HOLD: begin
                    if (start)                  next_state = ST_LOAD;
                    else if (hold_cnt == HOLD_LAST) next_state = ST_RUN;
                end
                ST_RUN: begin
                    if (start)                         next_state = ST_LOAD;
                    else if (found)                    next_state = ST_FOUND;
                    else if (solver_nonce == MAX_NONCE) next_state = ST_EXHAUSTED;
                end
                ST_FOUND, ST_EXHAUSTED: if (start) next_state = ST_LOAD;
                default:      next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from next_state so they line up with the state change.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            solver_rst_n <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_nonce <= '0;
        end else begin
            state        <= next_state;
            solver_rst_n <= (next_state == ST_RUN) || (next_state == ST_FOUND);
            busy         <= is_busy(next_state);
            done         <= (state == ST_RUN) &&
                            ((next_state == ST_FOUND) || (next_state == ST_EXHAUSTED));
            if (state == ST_LOAD)      hold_cnt <= '0;
            else if (state == ST_HOLD) hold_cnt <= hold_cnt + 4'd1;
            if ((state == ST_RUN) && (next_state == ST_FOUND)) result_nonce <= solver_nonce;
        end
    end

    assign status = state;

    assign work_in = '{midstate: work_midstate, leftovers: work_leftovers, target: work_target};

    work_latch u_work_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == ST_LOAD),
        .d     (work_in),
        .q     (work_q)
    );

    assign solver_midstate  = work_q.midstate;
    assign solver_leftovers = work_q.leftovers;
    assign solver_target    = work_q.target;

endmodule

// File: tb/tb_solver_sequencer.sv
// Directed bench for solver_sequencer: a vector table for the first job, then
// hand-written sequences for exhaustion, preemption, abort, priority and reset.
module tb_solver_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [255:0] work_midstate;
    logic [95:0]  work_leftovers;
    logic [255:0] work_target;
    logic [2:0]   solver_state;
    logic [31:0]  solver_nonce;
    logic         solver_rst_n;
    logic [255:0] solver_midstate;
    logic [95:0]  solver_leftovers;
    logic [255:0] solver_target;
    logic         busy;
    logic         done;
    logic [2:0]   status;
    logic [31:0]  result_nonce;

    int passed = 0;
    int total  = 0;

    solver_sequencer #(.RST_CYCLES(4), .MAX_NONCE(32'h10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .work_midstate    (work_midstate),
        .work_leftovers   (work_leftovers),
        .work_target      (work_target),
        .solver_state     (solver_state),
        .solver_nonce     (solver_nonce),
        .solver_rst_n     (solver_rst_n),
        .solver_midstate  (solver_midstate),
        .solver_leftovers (solver_leftovers),
        .solver_target    (solver_target),
        .busy             (busy),
        .done             (done),
        .status           (status),
        .result_nonce     (result_nonce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        found;
        logic [31:0] nonce;
        logic [2:0]  status;
        logic        busy;
        logic        done;
        logic        srst;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Pulse start, then wait out LOAD plus four HOLD cycles and confirm RUN.
    task automatic go_to_run(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check({name, "_status"}, 256'(status), 256'd3);
        check({name, "_srst"}, 256'(solver_rst_n), 256'd1);
    endtask

    initial begin
        //            start abort found nonce   status busy done srst result
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  3'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  3'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h28, 3'd3, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h29, 3'd3, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h2A, 3'd4, 1'b0, 1'b1, 1'b1, 32'h2A};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h2B, 3'd4, 1'b0, 1'b0, 1'b1, 32'h2A};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h2C, 3'd4, 1'b0, 1'b0, 1'b1, 32'h2A};

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        work_midstate  = 256'h1;
        work_leftovers = 96'hA;
        work_target    = '1;
        solver_state   = 3'b000;
        solver_nonce   = 32'h0;
        tick();
        tick();
        check("rst_status", 256'(status), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_srst", 256'(solver_rst_n), 256'd0);
        check("rst_result", 256'(result_nonce), 256'd0);
        check("rst_midstate", solver_midstate, 256'd0);
        rst_n = 1'b1;

        // First job: LOAD, four HOLD cycles, RUN five edges after LOAD, found at 0x2A.
        for (int i = 0; i < 11; i++) begin
            start           = vecs[i].start;
            abort           = vecs[i].abort;
            solver_state[2] = vecs[i].found;
            solver_nonce    = vecs[i].nonce;
            tick();
            check($sformatf("v%0d_status", i), 256'(status), 256'(vecs[i].status));
            check($sformatf("v%0d_busy", i), 256'(busy), 256'(vecs[i].busy));
            check($sformatf("v%0d_done", i), 256'(done), 256'(vecs[i].done));
            check($sformatf("v%0d_srst", i), 256'(solver_rst_n), 256'(vecs[i].srst));
            check($sformatf("v%0d_result", i), 256'(result_nonce), 256'(vecs[i].result));
        end
        check("a_midstate", solver_midstate, 256'h1);
        check("a_leftovers", 256'(solver_leftovers), 256'hA);
        check("a_target", solver_target, {256{1'b1}});
        solver_state = 3'b000;
        solver_nonce = 32'h0;

        // Exhaustion at MAX_NONCE=0x10 with no solution.
        go_to_run("b_run");
        solver_nonce = 32'h0E; tick();
        solver_nonce = 32'h0F; tick();
        check("b_pre_status", 256'(status), 256'd3);
        solver_nonce = 32'h10; tick();
        check("b_status", 256'(status), 256'd5);
        check("b_done", 256'(done), 256'd1);
        check("b_srst", 256'(solver_rst_n), 256'd0);
        check("b_busy", 256'(busy), 256'd0);
        check("b_result", 256'(result_nonce), 256'h2A);
        tick();
        check("b_done_fall", 256'(done), 256'd0);
        check("b_hold_status", 256'(status), 256'd5);
        solver_nonce = 32'h0;

        // Preempt a running job at nonce 0x100 with new work.
        go_to_run("c_run");
        solver_nonce = 32'h100; tick();
        check("c_run_status", 256'(status), 256'd3);
        work_midstate = 256'h2;
        start = 1'b1; tick(); start = 1'b0;
        check("c_load_status", 256'(status), 256'd1);
        check("c_load_srst", 256'(solver_rst_n), 256'd0);
        solver_nonce = 32'h0;
        tick();
        check("c_midstate", solver_midstate, 256'h2);
        check("c_hold_srst0", 256'(solver_rst_n), 256'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("c_hold_srst%0d", i), 256'(solver_rst_n), 256'd0);
        end
        tick();
        check("c_rise_srst", 256'(solver_rst_n), 256'd1);
        check("c_rise_status", 256'(status), 256'd3);

        // Abort and start together during HOLD: abort wins, no LOAD follows.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("d_hold_status", 256'(status), 256'd2);
        abort = 1'b1; start = 1'b1; tick();
        abort = 1'b0; start = 1'b0;
        check("d_status", 256'(status), 256'd0);
        check("d_busy", 256'(busy), 256'd0);
        check("d_srst", 256'(solver_rst_n), 256'd0);
        tick();
        check("d_no_load", 256'(status), 256'd0);

        // Found and nonce==MAX_NONCE together; target rewrite mid-run is ignored.
        go_to_run("e_run");
        work_target = 256'h1234;
        tick();
        solver_state = 3'b100; solver_nonce = 32'h10; tick();
        check("e_status", 256'(status), 256'd4);
        check("e_done", 256'(done), 256'd1);
        check("e_result", 256'(result_nonce), 256'h10);
        check("e_target", solver_target, {256{1'b1}});
        solver_state = 3'b000; solver_nonce = 32'h0;

        // Synchronous reset mid-run, with start held during reset.
        go_to_run("f_run");
        rst_n = 1'b0; start = 1'b1; tick();
        check("f_status", 256'(status), 256'd0);
        check("f_busy", 256'(busy), 256'd0);
        check("f_done", 256'(done), 256'd0);
        check("f_srst", 256'(solver_rst_n), 256'd0);
        check("f_result", 256'(result_nonce), 256'd0);
        check("f_midstate", solver_midstate, 256'd0);
        check("f_leftovers", 256'(solver_leftovers), 256'd0);
        check("f_target", solver_target, 256'd0);
        rst_n = 1'b1; start = 1'b0; tick();
        check("f_after_status", 256'(status), 256'd0);
        check("f_after_busy", 256'(busy), 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
